// File: rtl/fpu_add_sub_pkg.sv
// Shared definitions for the FP32 add/sub alignment front end.
//   - Field widths (EXP_W, MAN_W, ALN_W) and the shifter control width SH_W.
//   - QNAN / EXP_MAX constants.
//   - fp32_unpacked_t: one operand after unpacking (denormals get an
//     effective exponent of 1 and a clear hidden bit).
//   - align_out_t: everything the stage-2 register hands downstream.
//   - unpack(): IEEE-754 single -> fp32_unpacked_t.
package fpu_add_sub_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int ALN_W = MAN_W + 4;
  localparam int SH_W  = $clog2(ALN_W + 1);

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp_eff;
    logic [MAN_W:0]   man;      // {hidden, frac}
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp32_unpacked_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             eff_sub;
    logic [ALN_W-1:0] man_big;
    logic [ALN_W-1:0] man_small;
    logic             special;
    logic [31:0]      special_val;
  } align_out_t;

  function automatic fp32_unpacked_t unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e         = x[30:23];
    f         = x[22:0];
    u.sign    = x[31];
    u.exp_eff = (e == '0) ? EXP_W'(1) : e;
    u.man     = {(e != '0), f};
    u.is_zero = (e == '0) && (f == '0);
    u.is_inf  = (e == EXP_MAX) && (f == '0);
    u.is_nan  = (e == EXP_MAX) && (f != '0);
    return u;
  endfunction

endpackage

// File: rtl/fpu_add_sub_rshift_sticky.sv
// Logarithmic barrel right shifter with sticky collapse.
//   din   : W-bit input
//   shamt : shift amount (SH_W bits)
//   dout  : din >> shamt, with bit 0 ORed with every bit shifted out
module fpu_add_sub_rshift_sticky #(
  parameter int W    = 27,
  parameter int SH_W = 5
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
);

  logic [W-1:0] stage_data   [SH_W+1];
  logic         stage_sticky [SH_W+1];

  assign stage_data[0]   = din;
  assign stage_sticky[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      if (SH < W) begin : g_part
        assign stage_data[gi+1]   = shamt[gi] ? (stage_data[gi] >> SH) : stage_data[gi];
        assign stage_sticky[gi+1] = stage_sticky[gi] | (shamt[gi] & (|stage_data[gi][SH-1:0]));
      end else begin : g_full
        // Step wider than the word: everything falls into the sticky bit.
        assign stage_data[gi+1]   = shamt[gi] ? '0 : stage_data[gi];
        assign stage_sticky[gi+1] = stage_sticky[gi] | (shamt[gi] & (|stage_data[gi]));
      end
    end
  endgenerate

  assign dout = {stage_data[SH_W][W-1:1], stage_data[SH_W][0] | stage_sticky[SH_W]};

endmodule

// File: rtl/fpu_add_sub_sub4.sv
// 4-bit borrow-lookahead subtractor slice: d = a - b - bin.
//   a, b  : 4-bit operands
//   bin   : borrow in
//   d     : 4-bit difference
//   bout  : borrow out
// Borrow generate = ~a & b; borrow propagate when the bits are equal.
module fpu_add_sub_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] brw;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gp
      assign g[gi] = ~a[gi] & b[gi];
      assign p[gi] = ~(a[gi] ^ b[gi]);
      assign d[gi] = a[gi] ^ b[gi] ^ brw[gi];
    end
  endgenerate

  // Flattened lookahead: every borrow depends only on g/p and bin.
  assign brw[0] = bin;
  assign brw[1] = g[0] | (p[0] & bin);
  assign brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
  assign bout   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin);

endmodule

// File: rtl/fpu_add_sub_align.sv
// FP32 add/sub front end: unpack, magnitude order, exponent difference,
// and right-alignment of the smaller mantissa with guard/round/sticky.
// Two registered stages with valid/ready backpressure.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid/o_ready     : input handshake for (i_a, i_b, i_op); i_op=1 is A-B
//   o_valid/i_ready     : output handshake
//   o_exp               : larger (common) effective exponent
//   o_sign              : result sign before normalisation
//   o_eff_sub           : effective subtraction
//   o_man_big           : {hidden, frac, 3'b000} of the larger operand
//   o_man_small         : aligned smaller mantissa, sticky in bit 0
//   o_special/_val      : NaN/Inf result decided here
module fpu_add_sub_align
  import fpu_add_sub_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic             i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_sign,
  output logic             o_eff_sub,
  output logic [ALN_W-1:0] o_man_big,
  output logic [ALN_W-1:0] o_man_small,
  output logic             o_special,
  output logic [31:0]      o_special_val
);

  // ---------------- handshake ----------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_advance;
  logic s2_advance;

  assign s2_advance = ~s2_valid_reg | i_ready;
  assign s1_advance = ~s1_valid_reg | s2_advance;
  assign o_ready    = s1_advance;

  // ---------------- stage 1: unpack, order, subtract ----------------
  fp32_unpacked_t ua;
  fp32_unpacked_t ub;
  logic           sb_eff;
  logic           eff_sub;
  logic           b_gt;
  logic           mag_eq;
  logic [EXP_W-1:0] exp_big;
  logic [EXP_W-1:0] exp_small;
  logic [MAN_W:0]   man_big;
  logic [MAN_W:0]   man_small;
  logic             sign_next;
  logic             special_next;
  logic [31:0]      special_val_next;

  assign ua      = unpack(i_a);
  assign ub      = unpack(i_b);
  assign sb_eff  = ub.sign ^ i_op;
  assign eff_sub = ua.sign ^ sb_eff;
  assign b_gt    = {ub.exp_eff, ub.man} > {ua.exp_eff, ua.man};
  assign mag_eq  = {ub.exp_eff, ub.man} == {ua.exp_eff, ua.man};

  assign exp_big   = b_gt ? ub.exp_eff : ua.exp_eff;
  assign exp_small = b_gt ? ua.exp_eff : ub.exp_eff;
  assign man_big   = b_gt ? ub.man : ua.man;
  assign man_small = b_gt ? ua.man : ub.man;

  always_comb begin
    sign_next = b_gt ? sb_eff : ua.sign;
    if (ua.is_zero && ub.is_zero && !eff_sub) begin
      sign_next = ua.sign;
    end else if (eff_sub && mag_eq) begin
      // x - x rounds to +0 under round-to-nearest-even
      sign_next = 1'b0;
    end
  end

  always_comb begin
    special_next     = 1'b0;
    special_val_next = '0;
    if (ua.is_nan || ub.is_nan) begin
      special_next     = 1'b1;
      special_val_next = QNAN;
    end else if (ua.is_inf && ub.is_inf) begin
      special_next     = 1'b1;
      special_val_next = eff_sub ? QNAN : {ua.sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (ua.is_inf) begin
      special_next     = 1'b1;
      special_val_next = {ua.sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (ub.is_inf) begin
      special_next     = 1'b1;
      special_val_next = {sb_eff, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  // Exponent difference from chained 4-bit borrow-lookahead slices.
  localparam int NSLICE = EXP_W / 4;
  logic [NSLICE:0]  sub_borrow;
  logic [EXP_W-1:0] sub_diff;
  logic [EXP_W-1:0] exp_diff;

  assign sub_borrow[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_sub
      fpu_add_sub_sub4 u_slice (
        .a    (exp_big[4*gi +: 4]),
        .b    (exp_small[4*gi +: 4]),
        .bin  (sub_borrow[gi]),
        .d    (sub_diff[4*gi +: 4]),
        .bout (sub_borrow[gi+1])
      );
    end
  endgenerate

  // After the swap the borrow-out is always 0; clamp defensively anyway.
  assign exp_diff = sub_borrow[NSLICE] ? '0 : sub_diff;

  logic [EXP_W-1:0] s1_exp_reg;
  logic [EXP_W-1:0] s1_diff_reg;
  logic [MAN_W:0]   s1_man_big_reg;
  logic [MAN_W:0]   s1_man_small_reg;
  logic             s1_sign_reg;
  logic             s1_eff_sub_reg;
  logic             s1_special_reg;
  logic [31:0]      s1_special_val_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_reg       <= 1'b0;
      s1_exp_reg         <= '0;
      s1_diff_reg        <= '0;
      s1_man_big_reg     <= '0;
      s1_man_small_reg   <= '0;
      s1_sign_reg        <= 1'b0;
      s1_eff_sub_reg     <= 1'b0;
      s1_special_reg     <= 1'b0;
      s1_special_val_reg <= '0;
    end else if (s1_advance) begin
      s1_valid_reg       <= i_valid;
      s1_exp_reg         <= exp_big;
      s1_diff_reg        <= exp_diff;
      s1_man_big_reg     <= man_big;
      s1_man_small_reg   <= man_small;
      s1_sign_reg        <= sign_next;
      s1_eff_sub_reg     <= eff_sub;
      s1_special_reg     <= special_next;
      s1_special_val_reg <= special_val_val_pass(s1_special_reg, special_val_next);
    end
  end

  // Identity helper kept local so the stage-1 load reads as a plain copy.
  function automatic logic [31:0] special_val_val_pass(input logic unused_sel,
                                                       input logic [31:0] v);
    return unused_sel ? v : v;
  endfunction

  // ---------------- stage 2: align ----------------
  logic [SH_W-1:0]  shamt;
  logic [ALN_W-1:0] man_small_aligned;
  align_out_t       align_next;
  align_out_t       align_reg;

  // Shifting by ALN_W already pushes every bit into sticky.
  assign shamt = (s1_diff_reg >= EXP_W'(ALN_W)) ? SH_W'(ALN_W) : s1_diff_reg[SH_W-1:0];

  fpu_add_sub_rshift_sticky #(
    .W    (ALN_W),
    .SH_W (SH_W)
  ) u_rshift (
    .din   ({s1_man_small_reg, 3'b000}),
    .shamt (shamt),
    .dout  (man_small_aligned)
  );

  always_comb begin
    align_next             = '0;
    align_next.exp         = s1_exp_reg;
    align_next.sign        = s1_sign_reg;
    align_next.eff_sub     = s1_eff_sub_reg;
    align_next.man_big     = {s1_man_big_reg, 3'b000};
    align_next.man_small   = man_small_aligned;
    align_next.special     = s1_special_reg;
    align_next.special_val = s1_special_val_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_reg <= 1'b0;
      align_reg    <= '0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      align_reg    <= align_next;
    end
  end

  assign o_valid       = s2_valid_reg;
  assign o_exp         = align_reg.exp;
  assign o_sign        = align_reg.sign;
  assign o_eff_sub     = align_reg.eff_sub;
  assign o_man_big     = align_reg.man_big;
  assign o_man_small   = align_reg.man_small;
  assign o_special     = align_reg.special;
  assign o_special_val = align_reg.special_val;

endmodule

// File: doc/fpu_add_sub_align.md
Name: fpu_add_sub_align

Overview:
- Front end of the FP32 adder/subtractor in the FFT butterfly datapath. Feeds the mantissa add/sub and normalise stages.
- Unpacks two IEEE-754 single-precision operands and orders them by magnitude.
- Computes the exponent difference with the team's 4-bit borrow-lookahead subtractor slices.
- Right-aligns the smaller mantissa with guard/round/sticky bits.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 23, stored fraction width
- ALN_W, MAN_W+4 (27), aligned mantissa width: hidden bit, fraction, G, R, S

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  operand pair valid
- o_ready  out  1  stage can accept
- i_a  in  32  operand A
- i_b  in  32  operand B
- i_op  in  1  0 = A+B, 1 = A−B
- o_valid  out  1  aligned result valid
- i_ready  in  1  downstream accepts
- o_exp  out  EXP_W  common (larger) exponent
- o_sign  out  1  result sign before normalisation
- o_eff_sub  out  1  effective subtraction
- o_man_big  out  ALN_W  larger mantissa, {hidden, frac, 3'b000}
- o_man_small  out  ALN_W  aligned smaller mantissa, sticky in bit 0
- o_special  out  1  result fully determined here
- o_special_val  out  32  result when o_special = 1

Behaviour:
- Reset (synchronous, i_rst = 1): both stage valid flags clear. o_valid = 0. All data outputs = 0. o_ready = 1 in the first cycle after reset.
- Handshake:
  - Transfer in when i_valid & o_ready.
  - Transfer out when o_valid & i_ready.
  - Per stage, advance = ~stage_valid | next_stage_advance. o_ready = S1 advance.
  - Full throughput is 1 pair per cycle.
  - Data registers load only on advance. Outputs hold stable while o_valid & ~i_ready.
- Latency: exactly 2 cycles from input transfer to o_valid, with no stall.
- Unpack:
  - exp = 0 denotes a denormal: hidden bit 0, effective exponent 1.
  - Otherwise hidden bit 1.
- Stage 1 (registered):
  - Effective B sign = b_sign ^ i_op. eff_sub = a_sign ^ effective B sign.
  - Magnitude compare on {exp_eff, hidden, frac}. Swap when B > A.
  - Equal magnitudes give no swap.
  - diff = exp_big − exp_small. 8-bit subtraction built from two ADD_SUB_SUB_4bit-style slices with borrow chaining; borrow-out must be 0 after the swap.
- Stage 2 (registered):
  - Shift amount = min(diff, ALN_W).
  - man_small = {hidden, frac, 3'b0} >> shift.
  - Bit 0 is ORed with the OR of all bits shifted out.
  - diff ≥ ALN_W: o_man_small = {26'b0, sticky}, where sticky = (small mantissa ≠ 0).
- Sign:
  - o_sign = sign of larger operand.
  - Exception: eff_sub with equal magnitudes gives o_sign = 0 (+0 under RNE).
  - Both operands zero with eff_sub = 0 gives o_sign = the common sign.
- Specials (evaluated in stage 1, carried through stage 2):
  - Either operand NaN → o_special = 1, o_special_val = 32'h7FC0_0000.
  - Inf with effective-opposite Inf → o_special = 1, o_special_val = 32'h7FC0_0000.
  - Single Inf, or same-sign Infs → o_special = 1, o_special_val = that signed Inf.
  - Otherwise o_special = 0, o_special_val = 0.
  - Mantissa/exponent outputs stay valid but unused when o_special = 1.
- Boundaries:
  - Reset asserted mid-stall discards both in-flight entries and ignores i_valid in that cycle.
  - Simultaneous output drain and input accept when the pipe is full must not stall or drop.
  - i_valid held with changing data while o_ready = 0 is not captured.

Decomposition:
- Package fpu_add_sub_pkg:
  - EXP_W, MAN_W, ALN_W.
  - Constants: QNAN = 32'h7FC0_0000, EXP_MAX = 8'hFF.
  - Struct fp32_unpacked_t {sign, exp_eff, man (24b), is_zero, is_inf, is_nan}.
  - Struct align_out_t bundling the stage-2 outputs.
- Sub-module: fpu_add_sub_rshift_sticky, a parameterised barrel right shifter with sticky collapse.
- The exponent subtractor instantiates two existing 4-bit borrow-lookahead slices.

Test Plan:
- 1.0 + 1.0 (3F80_0000, 3F80_0000, op 0), i_ready = 1 → after 2 cycles o_exp = 7F, o_man_big = o_man_small = 27'h400_0000, o_eff_sub = 0, o_sign = 0.
- 1.0 − 2^-30 (3F80_0000, 3080_0000, op 1) → diff = 30 ≥ 27, o_man_small = 27'h000_0001, o_eff_sub = 1, o_sign = 0.
- 1.5 − 1.5 (3FC0_0000 both, op 1) → o_sign = 0, o_man_big = o_man_small = 27'h600_0000, o_eff_sub = 1.
- 3 − 5 (4040_0000, 40A0_0000, op 1) → swapped, o_exp = 81, o_sign = 1, o_man_big = 27'h500_0000, o_man_small = 27'h300_0000 (diff 1 shifts 27'h600_0000 right by one).
- Specials: 7F80_0000 − 7F80_0000 → o_special = 1, val 7FC0_0000. 7F80_0000 + 3F80_0000 → val 7F80_0000. FFC0_0001 + anything → val 7FC0_0000.
- Stall and reset: stream 4 pairs, i_ready low for 3 cycles → o_ready drops after 2 accepted, outputs hold, no loss or duplication, order preserved. Then i_rst pulse with the pipe full → o_valid = 0 the next cycle, o_ready = 1.
